// File: rtl/leaf_hub_link.sv
// Leaf-side endpoint of the root-hub link: decodes root frames into core payloads and
// round pulses, and frames local messages and status changes back up to the root.
module leaf_hub_link #(
  parameter int INTERCONNECT_WIDTH = 64,
  parameter int OPCODE_WIDTH       = 3,
  parameter int PAYLOAD_WIDTH      = INTERCONNECT_WIDTH - OPCODE_WIDTH,
  parameter int COUNT_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INTERCONNECT_WIDTH-1:0] upstream_fifo_in_data,
  input  logic                          upstream_fifo_in_valid,
  output logic                          upstream_fifo_in_ready,
  output logic [INTERCONNECT_WIDTH-1:0] upstream_fifo_out_data,
  output logic                          upstream_fifo_out_valid,
  input  logic                          upstream_fifo_out_ready,
  output logic [PAYLOAD_WIDTH-1:0]      core_in_data,
  output logic                          core_in_valid,
  input  logic                          core_in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]      core_out_data,
  input  logic                          core_out_valid,
  output logic                          core_out_ready,
  input  logic                          local_has_message_flying,
  input  logic                          local_has_odd_clusters,
  output logic                          new_round_start,
  output logic                          round_done,
  output logic                          upstream_has_message_flying,
  output logic                          upstream_has_odd_clusters,
  output logic [COUNT_WIDTH-1:0]        rx_data_count,
  output logic [COUNT_WIDTH-1:0]        tx_data_count,
  output logic                          protocol_error
);

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP    = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_START  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_DATA   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_DONE   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_STATUS = OPCODE_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, SEND_STATUS, SEND_DATA} out_state_t;

  out_state_t              state, state_next;
  logic                    running;
  logic [1:0]              last_sent_status;
  logic [1:0]              status_now;
  logic                    status_pending;
  logic                    in_accept, start_accept, out_free, load_status, load_data;
  logic [OPCODE_WIDTH-1:0] in_op;

  // running holds the link quiet for the first edge after reset releases
  assign in_op                  = upstream_fifo_in_data[INTERCONNECT_WIDTH-1 -: OPCODE_WIDTH];
  assign upstream_fifo_in_ready = running & (!core_in_valid | core_in_ready);
  assign in_accept              = upstream_fifo_in_valid & upstream_fifo_in_ready;
  assign start_accept           = in_accept & (in_op == OP_START);

  assign status_now              = {local_has_message_flying, local_has_odd_clusters};
  assign status_pending          = status_now != last_sent_status;
  assign upstream_fifo_out_valid = state != IDLE;
  assign out_free                = running & (!upstream_fifo_out_valid | upstream_fifo_out_ready);
  assign core_out_ready          = out_free & !status_pending;

  always_ff @(posedge clk) begin
    if (!reset) begin
      running         <= 1'b0;
      core_in_valid   <= 1'b0;
      core_in_data    <= '0;
      new_round_start <= 1'b0;
      round_done      <= 1'b0;
      rx_data_count   <= '0;
      protocol_error  <= 1'b0;
    end else begin
      running         <= 1'b1;
      new_round_start <= 1'b0;
      round_done      <= 1'b0;
      if (core_in_valid && core_in_ready) core_in_valid <= 1'b0;
      if (in_accept) begin
        case (in_op)
          OP_NOP: ;
          OP_START: begin
            new_round_start <= 1'b1;
            rx_data_count   <= '0;
            protocol_error  <= 1'b0;
          end
          OP_DATA: begin
            core_in_valid <= 1'b1;
            core_in_data  <= upstream_fifo_in_data[PAYLOAD_WIDTH-1:0];
            rx_data_count <= rx_data_count + COUNT_WIDTH'(1);
          end
          OP_DONE: round_done <= 1'b1;
          default: protocol_error <= 1'b1;
        endcase
      end
    end
  end

  // status frames win the output register over local data
  always_comb begin
    state_next  = state;
    load_status = 1'b0;
    load_data   = 1'b0;
    if (out_free) begin
      if (status_pending) begin
        state_next  = SEND_STATUS;
        load_status = 1'b1;
      end else if (core_out_valid) begin
        state_next = SEND_DATA;
        load_data  = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                  <= IDLE;
      upstream_fifo_out_data <= '0;
      last_sent_status       <= 2'b00;
      tx_data_count          <= '0;
    end else begin
      state <= state_next;
      if (load_status) begin
        upstream_fifo_out_data <= {OP_STATUS, PAYLOAD_WIDTH'(status_now)};
        last_sent_status       <= status_now;
      end else if (load_data) begin
        upstream_fifo_out_data <= {OP_DATA, core_out_data};
      end
      if (start_accept) tx_data_count <= '0;
      else if (load_data) tx_data_count <= tx_data_count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      upstream_has_message_flying <= 1'b0;
      upstream_has_odd_clusters   <= 1'b0;
    end else begin
      upstream_has_message_flying <= local_has_message_flying | core_in_valid |
                                     upstream_fifo_out_valid | status_pending |
                                     upstream_fifo_in_valid;
      upstream_has_odd_clusters   <= local_has_odd_clusters;
    end
  end

endmodule

// File: tb/tb_leaf_hub_link.sv
// Randomized bench for leaf_hub_link: stimulus pushes expected events into queues,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_leaf_hub_link;
  localparam int IW = 64, PW = IW - 3, CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [IW-1:0] in_data, out_data;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [PW-1:0] ci_data, co_data;
  logic          ci_valid, ci_ready, co_valid, co_ready;
  logic          lf, lo, nrs, rdone, fly, odd, perr;
  logic [CW-1:0] rxc, txc;

  leaf_hub_link dut (
    .clk(clk), .reset(reset),
    .upstream_fifo_in_data(in_data), .upstream_fifo_in_valid(in_valid),
    .upstream_fifo_in_ready(in_ready),
    .upstream_fifo_out_data(out_data), .upstream_fifo_out_valid(out_valid),
    .upstream_fifo_out_ready(out_ready),
    .core_in_data(ci_data), .core_in_valid(ci_valid), .core_in_ready(ci_ready),
    .core_out_data(co_data), .core_out_valid(co_valid), .core_out_ready(co_ready),
    .local_has_message_flying(lf), .local_has_odd_clusters(lo),
    .new_round_start(nrs), .round_done(rdone),
    .upstream_has_message_flying(fly), .upstream_has_odd_clusters(odd),
    .rx_data_count(rxc), .tx_data_count(txc), .protocol_error(perr)
  );

  typedef struct {int kind; logic [PW-1:0] data;} ev_t;  // kind: 0 DATA, 1 START, 2 DONE

  int checks = 0, passed = 0;
  ev_t           in_q[$];
  logic [IW-1:0] out_q[$];
  logic [IW-1:0] txq[$];
  logic [PW-1:0] coq[$];

  // reference model of round-level state
  int       m_rx = 0, m_tx = 0;
  bit       m_err = 0, m_occ = 0, m_ov = 0;
  logic [1:0] m_last = 2'b00;
  bit       prev_lo = 0;
  int       cir_mode = 1, or_mode = 1;
  bit       rnd = 0, fly_must = 0, run = 0;
  bit       prev_hold = 0;
  logic [IW-1:0] prev_od = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [PW-1:0] p);
    return {op, p};
  endfunction

  function automatic logic [IW-1:0] rand_frame();
    int r;
    logic [PW-1:0] p;
    r = $urandom % 16;
    p = PW'({$urandom, $urandom});
    if (r < 8) return mk(3'd2, p);
    if (r < 10) return mk(3'd1, p);
    if (r < 12) return mk(3'd3, p);
    if (r == 12) return mk(3'd0, p);
    return mk(3'($urandom_range(4, 7)), p);
  endfunction

  function automatic bit pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom % 4) != 0;
  endfunction

  // evaluate at negedge, update model and drive just after posedge, return at negedge
  task automatic cycle();
    bit acc, drain, ofree, pend, cohs, lds;
    logic [2:0] op;
    ev_t e;
    op = in_data[IW-1 -: 3];
    chk("core_in_valid", ci_valid, m_occ);
    chk("in_ready", in_ready, !m_occ || ci_ready);
    chk("out_valid", out_valid, m_ov);
    acc   = in_valid && (!m_occ || ci_ready);
    drain = m_occ && ci_ready;
    pend  = {lf, lo} != m_last;
    ofree = !m_ov || out_ready;
    chk("core_out_ready", co_ready, ofree && !pend);
    cohs = 0; lds = 0;
    if (ofree && pend) begin
      out_q.push_back(mk(3'd4, PW'({lf, lo}))); lds = 1;
    end else if (ofree && co_valid) begin
      out_q.push_back(mk(3'd2, co_data)); cohs = 1;
    end
    if (acc) begin
      e.data = in_data[PW-1:0];
      if (op == 3'd2) begin e.kind = 0; in_q.push_back(e); end
      if (op == 3'd1) begin e.kind = 1; in_q.push_back(e); end
      if (op == 3'd3) begin e.kind = 2; in_q.push_back(e); end
    end
    if (fly_must) chk("fly_hold", fly, 1);
    chk("odd_sideband", odd, prev_lo);
    prev_lo = lo;
    @(posedge clk); #1;
    if (drain) m_occ = 0;
    if (cohs) m_tx = (m_tx + 1) % 65536;
    if (lds) m_last = {lf, lo};
    if (ofree) m_ov = lds | cohs;
    if (acc) begin
      case (op)
        3'd0, 3'd3: ;
        3'd1: begin m_rx = 0; m_tx = 0; m_err = 0; end
        3'd2: begin m_rx = (m_rx + 1) % 65536; m_occ = 1; end
        default: m_err = 1;
      endcase
    end
    if (acc || !in_valid) begin
      if (txq.size() > 0) begin in_valid = 1; in_data = txq.pop_front(); end
      else if (rnd && ($urandom % 3) == 0) begin in_valid = 1; in_data = rand_frame(); end
      else in_valid = 0;
    end
    if (cohs || !co_valid) begin
      if (coq.size() > 0) begin co_valid = 1; co_data = coq.pop_front(); end
      else if (rnd && ($urandom % 3) == 0) begin co_valid = 1; co_data = PW'({$urandom, $urandom}); end
      else co_valid = 0;
    end
    ci_ready  = pick(cir_mode);
    out_ready = pick(or_mode);
    if (rnd && ($urandom % 10) == 0) begin lf = 1'($urandom); lo = 1'($urandom); end
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic pop_in(input int kind, input logic [PW-1:0] d, input bit has_data);
    ev_t e;
    if (in_q.size() == 0) begin
      chk("unexpected_in_event", 64'(kind), 64'hFF);
    end else begin
      e = in_q.pop_front();
      chk("in_event_kind", 64'(kind), 64'(e.kind));
      if (has_data) chk("core_in_data", d, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      if (nrs) pop_in(1, '0, 0);
      if (rdone) pop_in(2, '0, 0);
      if (ci_valid && ci_ready) pop_in(0, ci_data, 1);
      if (out_valid && prev_hold) chk("out_hold", out_data, prev_od);
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) chk("unexpected_out_frame", out_data, '0);
        else chk("out_frame", out_data, out_q.pop_front());
      end
      prev_hold = out_valid && !out_ready;
      prev_od   = out_data;
      chk("rx_data_count", rxc, 64'(m_rx));
      chk("tx_data_count", txc, 64'(m_tx));
      chk("protocol_error", perr, m_err);
    end
  end

  initial begin
    reset = 0; in_valid = 1; in_data = mk(3'd2, PW'(8'h15));
    ci_ready = 1; co_valid = 0; co_data = '0; out_ready = 1; lf = 0; lo = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_core_in_valid", ci_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_core_out_ready", co_ready, 0);
      chk("rst_pulses", {nrs, rdone}, 0);
      chk("rst_sideband", {fly, odd}, 0);
      chk("rst_counts", {rxc, txc}, 0);
      chk("rst_perr", perr, 0);
    end
    @(posedge clk); #1;
    reset = 1; in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    run = 1;

    // held DATA with core stalled, then drained
    cir_mode = 0; txq.push_back(mk(3'd2, PW'(8'h15)));
    run_cycles(5);
    cir_mode = 1; run_cycles(4);

    // frame ordering across START
    txq.push_back(mk(3'd2, PW'(8'hA1)));
    txq.push_back(mk(3'd2, PW'(8'hA2)));
    txq.push_back(mk(3'd1, '0));
    txq.push_back(mk(3'd2, PW'(8'hA3)));
    run_cycles(10);

    // status change races a local message: STATUS first
    lf = 1; lo = 0; coq.push_back(PW'(8'h07)); #1;
    run_cycles(6);
    lf = 0; #1;
    run_cycles(4);

    // root stalls with a frame pending
    or_mode = 0; coq.push_back(PW'(8'h09));
    run_cycles(3);
    fly_must = 1; run_cycles(5); fly_must = 0;
    or_mode = 1; run_cycles(3);

    // unknown opcode sticks until START
    txq.push_back(mk(3'd6, '0));
    txq.push_back(mk(3'd0, '0));
    run_cycles(5);
    txq.push_back(mk(3'd1, '0));
    run_cycles(4);

    // START accept coinciding with a core_out handshake
    txq.push_back(mk(3'd2, PW'(8'h11)));
    coq.push_back(PW'(8'h21));
    run_cycles(3);
    txq.push_back(mk(3'd1, '0));
    coq.push_back(PW'(8'h33));
    run_cycles(4);

    rnd = 1; cir_mode = 2; or_mode = 2;
    run_cycles(3000);

    rnd = 0; cir_mode = 1; or_mode = 1;
    run_cycles(30);
    chk("in_q_drained", 64'(in_q.size()), 0);
    chk("out_q_drained", 64'(out_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/leaf_hub_link.md
Name: leaf_hub_link

Overview:
- Child-side endpoint of the root-hub ↔ leaf interconnect; the opposite end of the root hub's downstream FIFO port.
- Accepts frames from the root hub's downstream channel and decodes them into local round-start pulses and payload messages for the local decoder core.
- Frames local outbound messages and status changes back to the root.
- Drives the upstream_has_message_flying / upstream_has_odd_clusters sideband the root uses for convergence and termination.

Parameters:
- INTERCONNECT_WIDTH, 64, frame width on both link directions.
- OPCODE_WIDTH, 3, opcode field at frame MSBs.
- PAYLOAD_WIDTH, INTERCONNECT_WIDTH-OPCODE_WIDTH, local message width (derived; never overridden).
- COUNT_WIDTH, 16, width of frame counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset; block is in reset on any rising clk edge where reset==0.
- upstream_fifo_in_data  in  INTERCONNECT_WIDTH  frame from root.
- upstream_fifo_in_valid  in  1  frame valid.
- upstream_fifo_in_ready  out  1  link accepts frame.
- upstream_fifo_out_data  out  INTERCONNECT_WIDTH  frame to root.
- upstream_fifo_out_valid  out  1  frame valid.
- upstream_fifo_out_ready  in  1  root accepts frame.
- core_in_data  out  PAYLOAD_WIDTH  decoded payload to local core.
- core_in_valid  out  1  payload valid.
- core_in_ready  in  1  core accepts payload.
- core_out_data  in  PAYLOAD_WIDTH  local message for root.
- core_out_valid  in  1  message valid.
- core_out_ready  out  1  link accepts message.
- local_has_message_flying  in  1  core has in-flight messages.
- local_has_odd_clusters  in  1  core has odd clusters.
- new_round_start  out  1  one-cycle pulse on START decode.
- round_done  out  1  one-cycle pulse on DONE decode.
- upstream_has_message_flying  out  1  registered sideband to root.
- upstream_has_odd_clusters  out  1  registered sideband to root.
- rx_data_count  out  COUNT_WIDTH  DATA frames received this round.
- tx_data_count  out  COUNT_WIDTH  DATA frames sent this round.
- protocol_error  out  1  sticky; unknown opcode seen.

Behaviour:
- Reset (reset==0 at clk edge): all valids, pulses, counters, protocol_error, sideband outputs and data registers go to 0; last_sent_status := 2'b00. Frames held in any register are discarded.
- Opcodes (frame[MSB -: 3]):
  - 3'd0 NOP: dropped.
  - 3'd1 START: pulse new_round_start; clear counters and protocol_error.
  - 3'd2 DATA: payload = frame[PAYLOAD_WIDTH-1:0].
  - 3'd3 DONE: pulse round_done.
  - 3'd4 STATUS: outbound only; payload bit1 = flying, bit0 = odd, other bits 0.
  - Any other inbound opcode, including STATUS: dropped; set protocol_error.
- Inbound path: single holding register.
  - upstream_fifo_in_ready = !core_in_valid | core_in_ready (combinational from register state).
  - Accepted DATA appears on core_in_* the next cycle; rx_data_count increments on accept, wrapping modulo 2^COUNT_WIDTH.
  - START/DONE/NOP never occupy the register. Pulses are asserted the cycle after accept.
  - START waits behind an undrained DATA through the ready rule, so frame order is preserved.
- Outbound path: one output register and an FSM with states IDLE, SEND_STATUS, SEND_DATA.
  - status_pending = {local_has_message_flying, local_has_odd_clusters} != last_sent_status.
  - In IDLE, or on handshake completion, the next frame is loaded with STATUS priority over DATA.
  - last_sent_status updates when the STATUS frame is loaded. The snapshot is taken at load time; later changes raise a new pending status.
  - core_out_ready = 1 only when the output register is empty or handshaking this cycle, and no status is pending.
  - tx_data_count increments on the core_out handshake.
  - upstream_fifo_out_data/valid stay stable while valid & !ready.
- Sideband outputs, registered with 1-cycle latency:
  - upstream_has_message_flying <= local_has_message_flying | core_in_valid | upstream_fifo_out_valid | status_pending | upstream_fifo_in_valid.
  - upstream_has_odd_clusters <= local_has_odd_clusters.
- Simultaneous START accept and core_out handshake: the counter clear wins over the tx increment (tx_data_count = 0).
- Reset while a root frame is valid: the frame is not accepted (ready=0 during reset).

Test Plan:
- Reset held 0 for 3 cycles with in_valid=1 → all outputs 0, in_ready=0; after release in_ready=1 next cycle.
- Inbound {3'd2, payload 0x15} with core_in_ready=0 for 4 cycles → core_in_data=0x15 valid from cycle+1, in_ready=0 until drained, rx_data_count=1.
- Back-to-back DATA, DATA, START, DATA with ready=1 → core sees 2 payloads, then a single new_round_start pulse, then rx_data_count=1 after the third DATA.
- local flags 00→10 while core_out_valid=1 with data 0x7, out_ready=1 → first frame STATUS payload 0b10, then DATA 0x7, tx_data_count=1.
- out_ready=0 for 5 cycles with a pending frame → data/valid held constant; upstream_has_message_flying=1 throughout.
- Inbound opcode 3'd6 → protocol_error=1 and stays 1; next START clears it to 0.
